// File: rtl/sim_data_checker_if.sv
// Stream interface between the pattern-generator path and the data checker.
// The master drives words and qualifiers, and the checker consumes them.
interface sim_data_checker_if;
  logic [31:0] DataIn;
  logic        DataInValid;
  logic        En;

  modport master (output DataIn, output DataInValid, output En);
  modport slave  (input  DataIn, input  DataInValid, input  En);
endinterface

// File: rtl/sim_data_checker.sv
// Pattern checker for a byte-count stream that is replicated four times per word.
// The first accepted word seeds the expected byte. Each later word is compared
// against the running count. On a mismatch the checker resyncs to the received
// byte, so one corrupted word costs exactly one error.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for a seed word; gap timer parked
//   CHECK | locked; each accepted word compared to {4{exp}}
module sim_data_checker #(
  parameter int ERR_CNT_W  = 16,
  parameter int WORD_CNT_W = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  sim_data_checker_if.slave     bus,
  output logic                  locked,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  err_flag,
  output logic [31:0]           first_err_data,
  output logic [31:0]           first_err_exp,
  output logic                  stall
);

  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT);

  typedef enum logic {IDLE, CHECK} state_t;

  state_t           state;
  logic [7:0]       exp;
  logic [GAP_W-1:0] gap_cnt;

  logic        accept;
  logic [31:0] cmp_word;
  logic        err_evt;

  // Decode the current word. A seed word is only checked for byte
  // replication, and a locked word is checked against the running count.
  always_comb begin
    accept   = bus.En & bus.DataInValid;
    cmp_word = (state == IDLE) ? {4{bus.DataIn[7:0]}} : {4{exp}};
    err_evt  = accept && (bus.DataIn != cmp_word);
  end

  // Checker FSM with counters, sticky flags and first-error capture. All of
  // these share one register block so that reset and clear act on them together.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state          <= IDLE;
      locked         <= 1'b0;
      exp            <= 8'h00;
      gap_cnt        <= '0;
      word_cnt       <= '0;
      err_cnt        <= '0;
      err_flag       <= 1'b0;
      first_err_data <= 32'h0;
      first_err_exp  <= 32'h0;
      stall          <= 1'b0;
    end else begin
      if (accept) begin
        // A matching word has DataIn[7:0] == exp, so seed, match and resync
        // all advance the expected byte the same way.
        exp     <= bus.DataIn[7:0] + 8'd1;
        gap_cnt <= '0;
        if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
        if (err_evt) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          err_flag <= 1'b1;
          if (!err_flag) begin
            first_err_data <= bus.DataIn;
            first_err_exp  <= cmp_word;
          end
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state  <= CHECK;
            locked <= 1'b1;
          end
        end
        CHECK: begin
          if (!bus.En) begin
            state   <= IDLE;
            locked  <= 1'b0;
            gap_cnt <= '0;
          end else if (!accept) begin
            // The gap timer holds at the limit. The stall flag stays set until reset or clear.
            if (gap_cnt != GAP_LIMIT) begin
              gap_cnt <= gap_cnt + 1'b1;
              if (gap_cnt + 1'b1 == GAP_LIMIT) stall <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sim_data_checker.md
SIM_DATA_CHECKER -- requirements
Module: sim_data_checker

Interface
REQ-001 Parameter ERR_CNT_W, default 16: width of the saturating error counter.
REQ-002 Parameter WORD_CNT_W, default 32: width of the saturating received-word counter.
REQ-003 Parameter TIMEOUT, default 1024: idle cycles while locked before the stall flag is raised (range 2..65535).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 En  input  1  check enable; level-sensitive.
REQ-007 clr  input  1  synchronous clear of counters, flags, capture registers; returns FSM to IDLE.
REQ-008 DataIn  input  32  word from the pattern generator path; pattern is the 8-bit count replicated four times.
REQ-009 DataInValid  input  1  qualifies DataIn; may deassert for any number of cycles (gaps legal).
REQ-010 locked  output  1  high in CHECK state.
REQ-011 word_cnt  output  WORD_CNT_W  words checked since reset/clr, saturating.
REQ-012 err_cnt  output  ERR_CNT_W  mismatching words, saturating.
REQ-013 err_flag  output  1  sticky: at least one mismatch since reset/clr.
REQ-014 first_err_data  output  32  DataIn of first mismatching word.
REQ-015 first_err_exp  output  32  expected word at first mismatch.
REQ-016 stall  output  1  sticky: TIMEOUT consecutive cycles without valid while locked.

Function
REQ-017 A word is accepted only when DataInValid=1 and En=1; words with En=0 are ignored and do not count.
REQ-018 FSM states: IDLE, CHECK; encoding free.
REQ-019 IDLE: on first accepted word, expected byte exp <= DataIn[7:0]+1 (mod 256), word_cnt increments, go to CHECK; seed word also checked for byte replication, mismatch counted as error with expected {4{DataIn[7:0]}}.
REQ-020 CHECK: accepted word compared to {4{exp}}; match -> exp <= exp+1 (mod 256); mismatch -> error event, exp <= DataIn[7:0]+1 (resync, so one corrupted word yields one error).
REQ-021 exp wraps 8'hFF -> 8'h00 with no error.
REQ-022 Error event: err_cnt+1 (saturate at all-ones), err_flag <= 1; if err_flag was 0, capture first_err_data/first_err_exp; later errors do not overwrite.
REQ-023 word_cnt saturates at all-ones; saturation does not stop checking.
REQ-024 All outputs registered; an accepted word at edge N is reflected in all outputs after edge N+1 (visible in cycle N+1).
REQ-025 Gap counter: in CHECK, counts cycles with no accepted word, resets to 0 on each accepted word; reaching TIMEOUT sets stall; counter holds at TIMEOUT.
REQ-026 En falling to 0 in CHECK: return to IDLE next edge; counters, flags, captures retained; next accepted word reseeds.
REQ-027 clr has priority over an accepted word in the same cycle; that word is dropped.
REQ-028 rst_n has priority over clr and all other inputs.

Reset
REQ-029 On rst_n=0 at a rising edge: FSM IDLE, locked=0, word_cnt=0, err_cnt=0, err_flag=0, first_err_data=0, first_err_exp=0, stall=0, gap counter=0, exp=0.
REQ-030 clr=1 produces the identical state of REQ-029.
REQ-031 Reset asserted mid-stream: the word on that edge is discarded; checking restarts with a fresh seed.

Verification
REQ-032 Clean stream 0x05050505..0x04040404 (256 words, wrap through 0xFF->0x00), En=1 -> word_cnt=256, err_cnt=0, err_flag=0, locked=1.
REQ-033 Stream 0x10..0x20 with word 0x15 replaced by 0x15FF1515 -> err_cnt=1, first_err_data=0x15FF1515, first_err_exp=0x15151515, words after resync clean.
REQ-034 Stream 0x00..0x09 with 0x05 dropped, random valid gaps of 0-7 cycles -> err_cnt=1, first_err_exp=0x05050505, first_err_data=0x06060606.
REQ-035 TIMEOUT=16: lock, then hold DataInValid=0 for 15 cycles -> stall=0; 16 cycles -> stall=1, stays 1 after traffic resumes until clr.
REQ-036 ERR_CNT_W=2, inject 5 errors -> err_cnt=3, first_err_* equal first error only; then clr with simultaneous valid word -> all outputs 0, locked=0, word_cnt=0.
REQ-037 Assert rst_n=0 for one cycle mid-stream at word 0x40 -> all outputs 0 next cycle; next valid 0x42424242 reseeds with no error.
